store_buffer: RTL and testbench
===============================

# store_buffer

FIFO write buffer between the MEM stage and the direct-mapped cache controller. Holds committed store hits (address and data) until the cache drains them one at a time, and forwards the youngest matching buffered store to loads in the same cycle. Full status is exported so MEM can stall the pipeline and force a drain.

## Interface
Parameters:
- ENTRY_COUNT, 4, number of entries; power of two, ≥2.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enq_valid  in  1  push request for {enq_addr, enq_data}.
- enq_addr  in  32  store byte address (word aligned).
- enq_data  in  32  store data.
- enq_ready  out  1  buffer can accept a push this cycle.
- deq_req  in  1  pop the head entry at this edge.
- deq_addr  out  32  head entry address.
- deq_data  out  32  head entry data.
- deq_valid  out  1  head entry exists (buffer not empty).
- load_addr  in  32  load address to match against buffered stores.
- sb_load_data  out  32  data of the youngest matching entry.
- sb_load_hit  out  1  a valid entry matches load_addr.
- count_out  out  $clog2(ENTRY_COUNT+1)  occupied entries; 3 bits at default.
- full  out  1  count_out == ENTRY_COUNT.
- flush  in  1  synchronous discard of all entries.

## Operation
- Storage is an array store_buf[0..ENTRY_COUNT-1] of {valid, addr[31:0], data[31:0]}. The field and array names are fixed because debug code accesses them hierarchically.
- Head and tail pointers each have $clog2(ENTRY_COUNT) bits and wrap modulo ENTRY_COUNT. count is kept as a separate register.
- Push: when enq_valid && enq_ready, write {1, enq_addr, enq_data} at tail, advance tail, count+1.
- enq_ready = ~full. A push while full is dropped, even if a pop happens in the same cycle.
- Pop: when deq_req && deq_valid, clear valid at head, advance head, count−1. deq_req while empty is ignored.
- A push and a pop in the same cycle (not full, not empty) both take effect. count is unchanged.
- deq_valid = (count != 0). deq_addr/deq_data show the head entry combinationally. They read 0 when empty.
- Forwarding is combinational:
  - Compare load_addr[31:2] with addr[31:2] of every valid entry.
  - On a hit, return the youngest match (the one closest to tail−1).
  - On a miss, sb_load_hit=0 and sb_load_data=0.
  - A same-cycle push is not visible until the next cycle.
- No coalescing: two stores to the same address occupy two entries.
- flush has priority over push and pop. It clears all valid bits, head, tail and count at the edge.
- Entries invalidated externally through the hierarchy are not resynchronised with count. The owner must also pulse flush.

## Timing
- Reset values: count_out=0, full=0, enq_ready=1, deq_valid=0, deq_addr=0, deq_data=0, sb_load_hit=0, sb_load_data=0. All entries are invalid and head=tail=0.
- Asserting reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Push latency is 1 cycle. The entry appears on count_out/deq_*/forwarding after the edge.
- Pop takes effect at the edge. The next head is visible in the same cycle after that edge.
- full, enq_ready, deq_valid and count_out are registered-state decodes with no combinational input paths.
- sb_load_* is combinational from load_addr and state.

## Configuration
- SB_CHECK_EN defined: simulation checks are compiled in. $error fires on a push while full, a pop while empty, or count exceeding ENTRY_COUNT.
- SB_CHECK_EN undefined: no checks. These events are silently ignored as described above.
- Synthesised logic is identical either way.

## Test plan
- Reset, then push {0x100, 0xAAAA0001} → next cycle count_out=1, deq_valid=1, deq_addr=0x100, deq_data=0xAAAA0001.
- Push 4 stores to 0x0, 0x4, 0x8, 0xC → full=1, enq_ready=0; a 5th push is dropped and count stays 4.
- Push 0x20←0x11, then 0x20←0x22; load_addr=0x20 → sb_load_hit=1, sb_load_data=0x22; load_addr=0x24 → hit=0.
- With 2 entries, push and pop in the same cycle → count stays 2, head advances. Pop 6 times through wrap-around → data returns in FIFO order, then deq_valid=0.
- Fill with 3 entries, assert flush together with enq_valid → count_out=0, all valid=0, push ignored.
- Assert reset asynchronously between edges with 3 entries → outputs go to reset values before the next edge.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer between MEM and the cache controller: an in-order FIFO of committed store hits
// with combinational youngest-match load forwarding. Define SB_CHECK_EN to compile in sim checks.
module store_buffer #(
  parameter int unsigned ENTRY_COUNT = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enq_valid,
  input  logic [31:0]                      enq_addr,
  input  logic [31:0]                      enq_data,
  output logic                             enq_ready,
  input  logic                             deq_req,
  output logic [31:0]                      deq_addr,
  output logic [31:0]                      deq_data,
  output logic                             deq_valid,
  input  logic [31:0]                      load_addr,
  output logic [31:0]                      sb_load_data,
  output logic                             sb_load_hit,
  output logic [$clog2(ENTRY_COUNT+1)-1:0] count_out,
  output logic                             full,
  input  logic                             flush
);

  localparam int unsigned PtrW = $clog2(ENTRY_COUNT);
  localparam int unsigned CntW = $clog2(ENTRY_COUNT + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  sb_entry_t store_buf [ENTRY_COUNT];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;
  logic do_push, do_pop;

  // Status decodes come only from registered state.
  assign full      = (count_q == cnt_t'(ENTRY_COUNT));
  assign enq_ready = ~full;
  assign deq_valid = (count_q != '0);
  assign count_out = count_q;

  assign do_push = enq_valid & enq_ready;
  assign do_pop  = deq_req & deq_valid;

  assign deq_addr = deq_valid ? store_buf[head_q].addr : '0;
  assign deq_data = deq_valid ? store_buf[head_q].data : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + ptr_t'(1);
      if (do_pop)  head_d = head_q + ptr_t'(1);
      if (do_push && !do_pop) begin
        count_d = count_q + cnt_t'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(ENTRY_COUNT); i++) begin
        store_buf[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (flush) begin
        for (int i = 0; i < int'(ENTRY_COUNT); i++) begin
          store_buf[i].valid <= 1'b0;
        end
      end else begin
        // Head and tail never coincide when both fire (not full, not empty).
        if (do_push) store_buf[tail_q] <= '{valid: 1'b1, addr: enq_addr, data: enq_data};
        if (do_pop)  store_buf[head_q].valid <= 1'b0;
      end
    end
  end

  // Walk oldest to youngest from head so the last match wins.
  always_comb begin
    ptr_t idx;
    sb_load_hit  = 1'b0;
    sb_load_data = '0;
    idx          = '0;
    for (int i = 0; i < int'(ENTRY_COUNT); i++) begin
      idx = head_q + ptr_t'(i);
      if (store_buf[idx].valid && (store_buf[idx].addr[31:2] == load_addr[31:2])) begin
        sb_load_hit  = 1'b1;
        sb_load_data = store_buf[idx].data;
      end
    end
  end

  logic unused_load_lsb;
  assign unused_load_lsb = ^load_addr[1:0];

`ifdef SB_CHECK_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (enq_valid && full && !flush) $error("store_buffer: push while full dropped");
      if (deq_req && !deq_valid && !flush) $error("store_buffer: pop while empty ignored");
      if (count_q > cnt_t'(ENTRY_COUNT)) $error("store_buffer: count exceeds ENTRY_COUNT");
    end
  end
`else
  // No simulation checks; illegal pushes/pops are silently gated by do_push/do_pop.
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized run against a
// queue-based reference model.
module tb_store_buffer;

  localparam int unsigned N = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        enq_valid;
  logic [31:0] enq_addr;
  logic [31:0] enq_data;
  logic        enq_ready;
  logic        deq_req;
  logic [31:0] deq_addr;
  logic [31:0] deq_data;
  logic        deq_valid;
  logic [31:0] load_addr;
  logic [31:0] sb_load_data;
  logic        sb_load_hit;
  logic [2:0]  count_out;
  logic        full;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  store_buffer #(.ENTRY_COUNT(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .enq_valid   (enq_valid),
    .enq_addr    (enq_addr),
    .enq_data    (enq_data),
    .enq_ready   (enq_ready),
    .deq_req     (deq_req),
    .deq_addr    (deq_addr),
    .deq_data    (deq_data),
    .deq_valid   (deq_valid),
    .load_addr   (load_addr),
    .sb_load_data(sb_load_data),
    .sb_load_hit (sb_load_hit),
    .count_out   (count_out),
    .full        (full),
    .flush       (flush)
  );

  always #5 clock = ~clock;

  task automatic idle_inputs();
    enq_valid = 1'b0;
    enq_addr  = '0;
    enq_data  = '0;
    deq_req   = 1'b0;
    load_addr = '0;
    flush     = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if ({count_out, full, enq_ready, deq_valid} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_status: got cnt=%0d full=%b rdy=%b dv=%b, want 0/0/1/0",
               count_out, full, enq_ready, deq_valid);
    end
    n_checks++;
    if ({deq_addr, deq_data, sb_load_hit, sb_load_data} !== 97'd0) begin
      n_fail++;
      $display("FAIL reset_data: got da=%h dd=%h hit=%b ld=%h, want all zero",
               deq_addr, deq_data, sb_load_hit, sb_load_data);
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_push_basic();
    enq_valid = 1'b1; enq_addr = 32'h100; enq_data = 32'hAAAA_0001;
    step();
    enq_valid = 1'b0;
    #1;
    n_checks++;
    if ({count_out, deq_valid, deq_addr, deq_data} !== {3'd1, 1'b1, 32'h100, 32'hAAAA_0001}) begin
      n_fail++;
      $display("FAIL push_basic: got cnt=%0d dv=%b da=%h dd=%h, want 1/1/100/aaaa0001",
               count_out, deq_valid, deq_addr, deq_data);
    end
    deq_req = 1'b1;
    step();
    deq_req = 1'b0;
    #1;
    n_checks++;
    if ({count_out, deq_valid, deq_addr, deq_data} !== {3'd0, 1'b0, 64'd0}) begin
      n_fail++;
      $display("FAIL pop_to_empty: got cnt=%0d dv=%b da=%h dd=%h, want 0/0/0/0",
               count_out, deq_valid, deq_addr, deq_data);
    end
  endtask

  task automatic test_full();
    enq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enq_addr = 32'(i * 4);
      enq_data = 32'hB000_0000 + 32'(i);
      step();
    end
    enq_valid = 1'b0;
    #1;
    n_checks++;
    if ({count_out, full, enq_ready, deq_valid} !== {3'd4, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL full_status: got cnt=%0d full=%b rdy=%b dv=%b, want 4/1/0/1",
               count_out, full, enq_ready, deq_valid);
    end
    // Push while full is dropped.
    enq_valid = 1'b1; enq_addr = 32'h10; enq_data = 32'hDEAD_0001;
    step();
    enq_valid = 1'b0; load_addr = 32'h10;
    #1;
    n_checks++;
    if ({count_out, sb_load_hit} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL full_drop: got cnt=%0d hit=%b, want 4/0", count_out, sb_load_hit);
    end
    // Push while full is dropped even with a same-cycle pop.
    enq_valid = 1'b1; enq_addr = 32'h10; enq_data = 32'hDEAD_0002; deq_req = 1'b1;
    step();
    enq_valid = 1'b0; deq_req = 1'b0;
    #1;
    n_checks++;
    if ({count_out, deq_addr, deq_data, sb_load_hit} !== {3'd3, 32'h4, 32'hB000_0001, 1'b0}) begin
      n_fail++;
      $display("FAIL full_drop_pop: got cnt=%0d da=%h dd=%h hit=%b, want 3/4/b0000001/0",
               count_out, deq_addr, deq_data, sb_load_hit);
    end
    deq_req = 1'b1;
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (deq_data !== 32'hB000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got %h want %h", i, deq_data, 32'hB000_0000 + 32'(i));
      end
      step();
    end
    deq_req = 1'b0;
    #1;
    n_checks++;
    if ({deq_valid, count_out} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL drain_empty: got dv=%b cnt=%0d want 0/0", deq_valid, count_out);
    end
  endtask

  task automatic test_forward();
    enq_valid = 1'b1; enq_addr = 32'h20; enq_data = 32'h11;
    step();
    enq_data = 32'h22;
    step();
    enq_valid = 1'b0; load_addr = 32'h20;
    #1;
    n_checks++;
    if ({sb_load_hit, sb_load_data} !== {1'b1, 32'h22}) begin
      n_fail++;
      $display("FAIL fwd_youngest: got hit=%b data=%h want 1/22", sb_load_hit, sb_load_data);
    end
    load_addr = 32'h23;
    #1;
    n_checks++;
    if ({sb_load_hit, sb_load_data} !== {1'b1, 32'h22}) begin
      n_fail++;
      $display("FAIL fwd_byte_offset: got hit=%b data=%h want 1/22", sb_load_hit, sb_load_data);
    end
    load_addr = 32'h24; enq_valid = 1'b1; enq_addr = 32'h24; enq_data = 32'h33;
    #1;
    n_checks++;
    if ({sb_load_hit, sb_load_data} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL fwd_miss_same_cycle: got hit=%b data=%h want 0/0", sb_load_hit, sb_load_data);
    end
    step();
    enq_valid = 1'b0;
    #1;
    n_checks++;
    if ({sb_load_hit, sb_load_data} !== {1'b1, 32'h33}) begin
      n_fail++;
      $display("FAIL fwd_after_push: got hit=%b data=%h want 1/33", sb_load_hit, sb_load_data);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    enq_valid = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      enq_addr = 32'h200 + 32'(k * 4); enq_data = 32'hC000_0000 + 32'(k);
      step();
    end
    deq_req = 1'b1;
    for (int k = 3; k <= 8; k++) begin
      enq_addr = 32'h200 + 32'(k * 4); enq_data = 32'hC000_0000 + 32'(k);
      #1;
      n_checks++;
      if ({count_out, deq_data} !== {3'd2, 32'hC000_0000 + 32'(k - 2)}) begin
        n_fail++;
        $display("FAIL push_pop[%0d]: got cnt=%0d dd=%h want 2/%h", k, count_out, deq_data,
                 32'hC000_0000 + 32'(k - 2));
      end
      step();
    end
    enq_valid = 1'b0;
    for (int k = 7; k <= 8; k++) begin
      #1;
      n_checks++;
      if (deq_data !== 32'hC000_0000 + 32'(k)) begin
        n_fail++;
        $display("FAIL tail_drain[%0d]: got %h want %h", k, deq_data, 32'hC000_0000 + 32'(k));
      end
      step();
    end
    deq_req = 1'b0;
    #1;
    n_checks++;
    if ({deq_valid, count_out} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL wrap_empty: got dv=%b cnt=%0d want 0/0", deq_valid, count_out);
    end
  endtask

  task automatic test_flush();
    logic any_valid;
    enq_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      enq_addr = 32'h300 + 32'(k * 4); enq_data = 32'hD000_0000 + 32'(k);
      step();
    end
    flush = 1'b1; enq_addr = 32'h400; enq_data = 32'hEEEE; deq_req = 1'b1;
    step();
    flush = 1'b0; enq_valid = 1'b0; deq_req = 1'b0; load_addr = 32'h304;
    #1;
    any_valid = 1'b0;
    for (int i = 0; i < int'(N); i++) any_valid |= dut.store_buf[i].valid;
    n_checks++;
    if ({count_out, deq_valid, any_valid, sb_load_hit} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush: got cnt=%0d dv=%b anyv=%b hit=%b want 0/0/0/0",
               count_out, deq_valid, any_valid, sb_load_hit);
    end
    load_addr = 32'h400;
    #1;
    n_checks++;
    if (sb_load_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_push_ignored: got hit=%b want 0", sb_load_hit);
    end
  endtask

  task automatic test_async_reset();
    enq_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      enq_addr = 32'h500 + 32'(k * 4); enq_data = 32'hF000_0000 + 32'(k);
      step();
    end
    enq_valid = 1'b0; load_addr = 32'h504;
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({count_out, full, enq_ready, deq_valid, deq_addr, deq_data, sb_load_hit, sb_load_data}
        !== {3'd0, 1'b0, 1'b1, 1'b0, 97'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got cnt=%0d rdy=%b dv=%b da=%h dd=%h hit=%b ld=%h",
               count_out, enq_ready, deq_valid, deq_addr, deq_data, sb_load_hit, sb_load_data);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_random();
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] ea, ed, exp_ld, da, dd, qa;
    logic        exp_hit, push_ok, pop_ok;
    int          sz;
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int c = 0; c < 400; c++) begin
      enq_valid = 1'($urandom_range(0, 1));
      enq_addr  = 32'($urandom_range(0, 7)) << 2;
      enq_data  = $urandom;
      deq_req   = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      load_addr = (32'($urandom_range(0, 8)) << 2) | 32'($urandom_range(0, 3));
      #1;
      sz = q_addr.size();
      exp_hit = 1'b0; exp_ld = '0;
      for (int i = 0; i < sz; i++) begin
        qa = q_addr[i];
        if (qa[31:2] == load_addr[31:2]) begin
          exp_hit = 1'b1; exp_ld = q_data[i];
        end
      end
      da = (sz != 0) ? q_addr[0] : '0;
      dd = (sz != 0) ? q_data[0] : '0;
      n_checks++;
      if ({count_out, full, enq_ready, deq_valid} !==
          {3'(sz), sz == int'(N), sz != int'(N), sz != 0}) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: got cnt=%0d full=%b rdy=%b dv=%b want cnt=%0d",
                 c, count_out, full, enq_ready, deq_valid, sz);
      end
      n_checks++;
      if ({deq_addr, deq_data} !== {da, dd}) begin
        n_fail++;
        $display("FAIL rand_head[%0d]: got %h/%h want %h/%h", c, deq_addr, deq_data, da, dd);
      end
      n_checks++;
      if ({sb_load_hit, sb_load_data} !== {exp_hit, exp_ld}) begin
        n_fail++;
        $display("FAIL rand_fwd[%0d]: got %b/%h want %b/%h", c, sb_load_hit, sb_load_data,
                 exp_hit, exp_ld);
      end
      ea = enq_addr; ed = enq_data;
      step();
      if (flush) begin
        q_addr.delete();
        q_data.delete();
      end else begin
        push_ok = enq_valid && (sz < int'(N));
        pop_ok  = deq_req && (sz > 0);
        if (pop_ok) begin
          void'(q_addr.pop_front());
          void'(q_data.pop_front());
        end
        if (push_ok) begin
          q_addr.push_back(ea);
          q_data.push_back(ed);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_full();
    test_forward();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
